// File: rtl/trdb_pkg.sv
// Shared trace-debug types: filter controller state encoding and registered pulse bundle.
// Optional statistics outputs elsewhere are enabled by TRDB_FILTER_CTRL_STATS_EN.
package trdb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    ARMED   = 3'd1,
    TRACING = 3'd2,
    HOLD    = 3'd3,
    DRAIN   = 3'd4
  } filter_ctrl_state_e;

  typedef struct packed {
    logic qualified;
    logic start;
    logic stop;
  } ctrl_pulse_t;

endpackage

// File: rtl/trdb_filter_ctrl_if.sv
// Filter controller bus: control regs, filter and encoder signals seen from the controller.
// TRDB_FILTER_CTRL_STATS_EN adds the window/qualified statistics outputs.
interface trdb_filter_ctrl_if #(parameter int HOLDOFF_W = 8);
  import trdb_pkg::*;

  logic                 trace_activate_i;
  logic                 trace_deactivate_i;
  logic                 iretire_i;
  logic                 nc_qualified_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic                 flush_ack_i;
  logic                 filter_en_o;
  logic                 qualified_o;
  logic                 start_o;
  logic                 stop_o;
  logic                 flush_req_o;
  logic [2:0]           state_o;
`ifdef TRDB_FILTER_CTRL_STATS_EN
  logic [31:0]          win_cnt_o;
  logic [XLEN-1:0]      qual_cnt_o;
`endif

  modport slave (
    input  trace_activate_i, trace_deactivate_i, iretire_i, nc_qualified_i,
           holdoff_i, flush_ack_i,
    output filter_en_o, qualified_o, start_o, stop_o, flush_req_o, state_o
`ifdef TRDB_FILTER_CTRL_STATS_EN
    , output win_cnt_o, qual_cnt_o
`endif
  );

  modport master (
    output trace_activate_i, trace_deactivate_i, iretire_i, nc_qualified_i,
           holdoff_i, flush_ack_i,
    input  filter_en_o, qualified_o, start_o, stop_o, flush_req_o, state_o
`ifdef TRDB_FILTER_CTRL_STATS_EN
    , input win_cnt_o, qual_cnt_o
`endif
  );

endinterface

// File: rtl/trdb_holdoff_cnt.sv
// Retire-counted holdoff: loaded on entry to HOLD, decremented per unqualified retire, never wraps.
module trdb_holdoff_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = dec_i && (cnt_q == W'(1));

endmodule

// File: rtl/trdb_filter_ctrl.sv
// Trace window sequencer around the non-compressed filter; handshakes an encoder flush on close.
// TRDB_FILTER_CTRL_STATS_EN adds win_cnt_o / qual_cnt_o counters.
module trdb_filter_ctrl
  import trdb_pkg::*;
#(
  parameter int HOLDOFF_W = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  trdb_filter_ctrl_if.slave bus
);

  filter_ctrl_state_e state_q, state_d;
  ctrl_pulse_t        pulse_q, pulse_d;
  logic               act, ret_q, ret_nq, ho_load, ho_dec, ho_last;
`ifdef TRDB_FILTER_CTRL_STATS_EN
  logic [31:0]        win_cnt_q;
  logic [XLEN-1:0]    qual_cnt_q;
`endif

  // A dropped activate level behaves exactly like a deactivate pulse.
  assign act    = bus.trace_activate_i && !bus.trace_deactivate_i;
  assign ret_q  = bus.iretire_i && bus.nc_qualified_i;
  assign ret_nq = bus.iretire_i && !bus.nc_qualified_i;

  assign ho_load = (state_q == TRACING) && act && ret_nq && (bus.holdoff_i != '0);
  assign ho_dec  = (state_q == HOLD) && act && ret_nq;

  trdb_holdoff_cnt #(.W(HOLDOFF_W)) u_holdoff (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ho_load),
    .load_val_i (bus.holdoff_i),
    .dec_i      (ho_dec),
    .last_o     (ho_last)
  );

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    unique case (state_q)
      OFF: if (act) state_d = ARMED;
      ARMED: begin
        if (!act) state_d = OFF;
        else if (ret_q) begin
          state_d           = TRACING;
          pulse_d.start     = 1'b1;
          pulse_d.qualified = 1'b1;
        end
      end
      TRACING: begin
        if (!act) begin
          state_d      = DRAIN;
          pulse_d.stop = 1'b1;
        end else if (ret_q) begin
          pulse_d.qualified = 1'b1;
        end else if (ret_nq) begin
          if (bus.holdoff_i == '0) begin
            state_d      = DRAIN;
            pulse_d.stop = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!act) begin
          state_d      = DRAIN;
          pulse_d.stop = 1'b1;
        end else if (ret_q) begin
          state_d           = TRACING;
          pulse_d.qualified = 1'b1;
        end else if (ho_last) begin
          state_d      = DRAIN;
          pulse_d.stop = 1'b1;
        end
      end
      // stop_q is high exactly in the DRAIN entry cycle, so it masks an early ack.
      DRAIN: if (bus.flush_ack_i && !pulse_q.stop) state_d = act ? ARMED : OFF;
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= OFF;
      pulse_q    <= '0;
`ifdef TRDB_FILTER_CTRL_STATS_EN
      win_cnt_q  <= '0;
      qual_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
`ifdef TRDB_FILTER_CTRL_STATS_EN
      if (state_q == OFF && state_d == ARMED) begin
        win_cnt_q  <= '0;
        qual_cnt_q <= '0;
      end else begin
        if (pulse_d.start)     win_cnt_q  <= win_cnt_q + 32'd1;
        if (pulse_d.qualified) qual_cnt_q <= qual_cnt_q + XLEN'(1);
      end
`endif
    end
  end

  assign bus.filter_en_o = (state_q == ARMED) || (state_q == TRACING) || (state_q == HOLD);
  assign bus.flush_req_o = (state_q == DRAIN);
  assign bus.qualified_o = pulse_q.qualified;
  assign bus.start_o     = pulse_q.start;
  assign bus.stop_o      = pulse_q.stop;
  assign bus.state_o     = state_q;
`ifdef TRDB_FILTER_CTRL_STATS_EN
  assign bus.win_cnt_o   = win_cnt_q;
  assign bus.qual_cnt_o  = qual_cnt_q;
`endif

endmodule

// File: tb/tb_trdb_filter_ctrl.sv
// Scenario bench for trdb_filter_ctrl; pulse outputs are scoreboarded one cycle after each drive.
// Stats scenario is compiled when TRDB_FILTER_CTRL_STATS_EN is defined.
module tb_trdb_filter_ctrl;
  import trdb_pkg::*;

  typedef struct {
    logic q;
    logic st;
    logic sp;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk_i = ~clk_i;

  trdb_filter_ctrl_if #(.HOLDOFF_W(8)) bus ();
  trdb_filter_ctrl #(.HOLDOFF_W(8)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  // Scoreboard: each entry describes the registered pulses after the next rising edge.
  always begin
    @(posedge clk_i);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({bus.qualified_o, bus.start_o, bus.stop_o} !== {e.q, e.st, e.sp})
        $display("FAIL pulses t=%0t q/start/stop got %b%b%b expected %b%b%b", $time,
                 bus.qualified_o, bus.start_o, bus.stop_o, e.q, e.st, e.sp);
      else n_pass++;
    end
  end

  task automatic cyc(input logic act, input logic deact, input logic ret, input logic qual,
                     input logic [7:0] ho, input logic ack,
                     input logic eq, input logic est, input logic esp);
    exp_t x;
    bus.trace_activate_i   = act;
    bus.trace_deactivate_i = deact;
    bus.iretire_i          = ret;
    bus.nc_qualified_i     = qual;
    bus.holdoff_i          = ho;
    bus.flush_ack_i        = ack;
    x.q = eq; x.st = est; x.sp = esp;
    sb.push_back(x);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.trace_activate_i = 0; bus.trace_deactivate_i = 0; bus.iretire_i = 0;
    bus.nc_qualified_i = 0; bus.holdoff_i = 0; bus.flush_ack_i = 0;
    #1;
    n_chk++;
    if ({bus.state_o, bus.filter_en_o, bus.flush_req_o, bus.qualified_o, bus.start_o, bus.stop_o}
        !== {3'd0, 5'b0})
      $display("FAIL reset_outputs got state=%0d en=%b flush=%b q=%b st=%b sp=%b expected all 0",
               bus.state_o, bus.filter_en_o, bus.flush_req_o, bus.qualified_o, bus.start_o, bus.stop_o);
    else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_arm_start();
    cyc(1,0,0,0,0,0, 0,0,0);
    n_chk++;
    if ({bus.state_o, bus.filter_en_o} !== {3'(ARMED), 1'b1})
      $display("FAIL arm_state got state=%0d en=%b expected 1/1", bus.state_o, bus.filter_en_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(1,0,1,0,0,0, 0,0,0);
      n_chk++;
      if (bus.state_o !== 3'(ARMED)) $display("FAIL arm_unqual%0d got %0d expected 1", i, bus.state_o);
      else n_pass++;
    end
    cyc(1,0,1,1,0,0, 1,1,0);
    n_chk++;
    if (bus.state_o !== 3'(TRACING)) $display("FAIL arm_to_tracing got %0d expected 2", bus.state_o);
    else n_pass++;
    cyc(1,0,0,0,0,0, 0,0,0);
    cyc(1,0,1,1,0,0, 1,0,0);
  endtask

  task automatic test_holdoff();
    cyc(1,0,1,0,8'd2,0, 0,0,0);
    n_chk++;
    if ({bus.state_o, bus.filter_en_o} !== {3'(HOLD), 1'b1})
      $display("FAIL hold_enter got state=%0d en=%b expected 3/1", bus.state_o, bus.filter_en_o);
    else n_pass++;
    cyc(1,0,0,0,8'd2,0, 0,0,0);
    cyc(1,0,0,0,8'd2,0, 0,0,0);
    cyc(1,0,1,1,8'd2,0, 1,0,0);
    n_chk++;
    if (bus.state_o !== 3'(TRACING)) $display("FAIL hold_requal got %0d expected 2", bus.state_o);
    else n_pass++;
    cyc(1,0,1,0,8'd2,0, 0,0,0);
    cyc(1,0,1,0,8'd0,0, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(HOLD)) $display("FAIL hold_cnt1 got %0d expected 3", bus.state_o);
    else n_pass++;
    cyc(1,0,0,0,8'd0,0, 0,0,0);
    cyc(1,0,1,0,8'd0,0, 0,0,1);
    n_chk++;
    if ({bus.state_o, bus.flush_req_o, bus.filter_en_o} !== {3'(DRAIN), 1'b1, 1'b0})
      $display("FAIL hold_drain got state=%0d flush=%b en=%b expected 4/1/0",
               bus.state_o, bus.flush_req_o, bus.filter_en_o);
    else n_pass++;
    cyc(1,0,0,0,0,1, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(DRAIN)) $display("FAIL drain_entry_ack got %0d expected 4", bus.state_o);
    else n_pass++;
    cyc(1,0,0,0,0,1, 0,0,0);
    n_chk++;
    if ({bus.state_o, bus.flush_req_o} !== {3'(ARMED), 1'b0})
      $display("FAIL drain_rearm got state=%0d flush=%b expected 1/0", bus.state_o, bus.flush_req_o);
    else n_pass++;
  endtask

  task automatic test_holdoff_zero();
    cyc(1,0,1,1,0,0, 1,1,0);
    cyc(1,0,1,0,0,0, 0,0,1);
    for (int i = 0; i < 5; i++) begin
      cyc(1,0,0,0,0,0, 0,0,0);
      n_chk++;
      if ({bus.state_o, bus.flush_req_o} !== {3'(DRAIN), 1'b1})
        $display("FAIL flush_hold%0d got state=%0d flush=%b expected 4/1", i, bus.state_o, bus.flush_req_o);
      else n_pass++;
    end
    cyc(1,0,0,0,0,1, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(ARMED)) $display("FAIL ho0_rearm got %0d expected 1", bus.state_o);
    else n_pass++;
  endtask

  task automatic test_deact();
    cyc(1,1,0,0,0,0, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(OFF)) $display("FAIL deact_armed got %0d expected 0", bus.state_o);
    else n_pass++;
    cyc(1,1,0,0,0,0, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(OFF)) $display("FAIL deact_wins_off got %0d expected 0", bus.state_o);
    else n_pass++;
    cyc(1,0,0,0,0,0, 0,0,0);
    cyc(1,0,1,1,0,0, 1,1,0);
    cyc(1,0,1,0,8'd3,0, 0,0,0);
    cyc(1,1,0,0,8'd3,0, 0,0,1);
    cyc(1,1,0,0,0,0, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(DRAIN)) $display("FAIL deact_in_drain got %0d expected 4", bus.state_o);
    else n_pass++;
    cyc(1,1,0,0,0,1, 0,0,0);
    n_chk++;
    if ({bus.state_o, bus.flush_req_o} !== {3'(OFF), 1'b0})
      $display("FAIL deact_ack_off got state=%0d flush=%b expected 0/0", bus.state_o, bus.flush_req_o);
    else n_pass++;
    cyc(1,0,0,0,0,0, 0,0,0);
    cyc(1,0,1,1,0,0, 1,1,0);
    cyc(0,0,0,0,0,0, 0,0,1);
    n_chk++;
    if (bus.state_o !== 3'(DRAIN)) $display("FAIL act_drop_drain got %0d expected 4", bus.state_o);
    else n_pass++;
    cyc(0,0,0,0,0,0, 0,0,0);
    cyc(0,0,0,0,0,1, 0,0,0);
    n_chk++;
    if (bus.state_o !== 3'(OFF)) $display("FAIL act_drop_off got %0d expected 0", bus.state_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc(1,0,0,0,0,0, 0,0,0);
    cyc(1,0,1,1,0,0, 1,1,0);
    rst_ni = 1'b0;
    bus.trace_activate_i = 1'b0;
    #1;
    n_chk++;
    if ({bus.state_o, bus.filter_en_o, bus.flush_req_o, bus.qualified_o, bus.start_o, bus.stop_o}
        !== {3'd0, 5'b0})
      $display("FAIL reset_mid got state=%0d en=%b flush=%b q=%b st=%b sp=%b expected all 0",
               bus.state_o, bus.filter_en_o, bus.flush_req_o, bus.qualified_o, bus.start_o, bus.stop_o);
    else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(0,0,0,0,0,0, 0,0,0);
    cyc(0,0,0,0,0,0, 0,0,0);
    n_chk++;
    if ({bus.state_o, bus.flush_req_o} !== {3'(OFF), 1'b0})
      $display("FAIL reset_mid_after got state=%0d flush=%b expected 0/0", bus.state_o, bus.flush_req_o);
    else n_pass++;
  endtask

`ifdef TRDB_FILTER_CTRL_STATS_EN
  task automatic test_stats();
    cyc(1,0,0,0,0,0, 0,0,0);
    cyc(1,0,1,1,0,0, 1,1,0);
    for (int i = 0; i < 2; i++) cyc(1,0,1,1,0,0, 1,0,0);
    cyc(1,1,0,0,0,0, 0,0,1);
    cyc(1,0,0,0,0,1, 0,0,0);
    cyc(1,0,0,0,0,1, 0,0,0);
    cyc(1,0,1,1,0,0, 1,1,0);
    for (int i = 0; i < 3; i++) cyc(1,0,1,1,0,0, 1,0,0);
    cyc(1,1,0,0,0,0, 0,0,1);
    cyc(0,0,0,0,0,1, 0,0,0);
    cyc(0,0,0,0,0,1, 0,0,0);
    n_chk++;
    if ({bus.win_cnt_o, bus.qual_cnt_o} !== {32'd2, XLEN'(7)})
      $display("FAIL stats_count got win=%0d qual=%0d expected 2/7", bus.win_cnt_o, bus.qual_cnt_o);
    else n_pass++;
    cyc(1,0,0,0,0,0, 0,0,0);
    n_chk++;
    if ({bus.win_cnt_o, bus.qual_cnt_o} !== {32'd0, XLEN'(0)})
      $display("FAIL stats_clear got win=%0d qual=%0d expected 0/0", bus.win_cnt_o, bus.qual_cnt_o);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_arm_start();
    test_holdoff();
    test_holdoff_zero();
    test_deact();
    test_reset_mid();
`ifdef TRDB_FILTER_CTRL_STATS_EN
    test_stats();
`endif
    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
